// File: rtl/sum_table_ctrl.sv
// Controller for a 2^(2*NW) x (NW+1) synchronous sum RAM: fills addr {a,b} with a+b,
// then serves 4-phase req/ack lookups through registered RAM reads.
module sum_table_ctrl #(
    parameter int unsigned NW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              req,
    input  logic [NW-1:0]     A,
    input  logic [NW-1:0]     B,
    output logic              busy,
    output logic              ready,
    output logic              ack,
    output logic [NW:0]       sum,
    output logic              err,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [2*NW-1:0]   ram_addr,
    output logic [NW:0]       ram_din,
    input  logic [NW:0]       ram_dout
);

    localparam int unsigned AW = 2 * NW;
    localparam int unsigned DW = NW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_READY = 3'd2;
    localparam logic [2:0] S_RD    = 3'd3;
    localparam logic [2:0] S_CAP   = 3'd4;

    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

    logic [2:0]    state_q,     state_d;
    logic [AW-1:0] cnt_q,       cnt_d;
    logic          busy_q,      busy_d;
    logic          ready_q,     ready_d;
    logic          ack_q,       ack_d;
    logic [DW-1:0] sum_q,       sum_d;
    logic          err_q,       err_d;
    logic          ram_cs_q,    ram_cs_d;
    logic          ram_we_q,    ram_we_d;
    logic [AW-1:0] ram_addr_q,  ram_addr_d;
    logic [DW-1:0] ram_din_q,   ram_din_d;
    logic          req_armed_q, req_armed_d;
    logic [NW-1:0] a_q,         a_d;
    logic [NW-1:0] b_q,         b_d;

    logic [AW-1:0] cnt_nxt;
    logic [DW-1:0] din_nxt;
    logic [DW-1:0] sum_ref;

    assign cnt_nxt = cnt_q + AW'(1);
    assign din_nxt = DW'(cnt_nxt[AW-1:NW]) + DW'(cnt_nxt[NW-1:0]);
    assign sum_ref = DW'(a_q) + DW'(b_q);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        ack_d       = 1'b0;
        sum_d       = sum_q;
        err_d       = err_q;
        ram_cs_d    = ram_cs_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        req_armed_d = req ? req_armed_q : 1'b1;
        a_d         = a_q;
        b_d         = b_q;

        case (state_q)
            S_IDLE, S_READY: begin
                ram_cs_d = 1'b0;
                ram_we_d = 1'b0;
                if (start) begin
                    // First write (address 0, data 0) is issued on the accepting edge
                    state_d    = S_FILL;
                    cnt_d      = '0;
                    ram_addr_d = '0;
                    ram_din_d  = '0;
                    ram_cs_d   = 1'b1;
                    ram_we_d   = 1'b1;
                    busy_d     = 1'b1;
                    ready_d    = 1'b0;
                    err_d      = 1'b0;
                end else if (state_q == S_READY && req && req_armed_q && !ack_q) begin
                    state_d     = S_RD;
                    a_d         = A;
                    b_d         = B;
                    ram_cs_d    = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = {A, B};
                    req_armed_d = 1'b0;
                end
            end
            S_FILL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_READY;
                    ram_cs_d = 1'b0;
                    ram_we_d = 1'b0;
                    busy_d   = 1'b0;
                    ready_d  = 1'b1;
                end else begin
                    cnt_d      = cnt_nxt;
                    ram_addr_d = cnt_nxt;
                    ram_din_d  = din_nxt;
                end
            end
            S_RD: begin
                ram_cs_d = 1'b0;
                state_d  = S_CAP;
            end
            S_CAP: begin
                sum_d   = ram_dout;
                ack_d   = 1'b1;
                err_d   = err_q | (ram_dout != sum_ref);
                state_d = S_READY;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            sum_q       <= '0;
            err_q       <= 1'b0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            req_armed_q <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            ack_q       <= ack_d;
            sum_q       <= sum_d;
            err_q       <= err_d;
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            req_armed_q <= req_armed_d;
            a_q         <= a_d;
            b_q         <= b_d;
        end
    end

    assign busy     = busy_q;
    assign ready    = ready_q;
    assign ack      = ack_q;
    assign sum      = sum_q;
    assign err      = err_q;
    assign ram_cs   = ram_cs_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_sum_table_ctrl.sv
// Bench for sum_table_ctrl: behavioural sum RAM with fault injection, fill/read/ack monitors
// and a scoreboard of outstanding lookups checked against plain a+b arithmetic.
module tb_sum_table_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, req;
    logic [3:0] A, B;
    logic       busy, ready, ack, err, ram_cs, ram_we;
    logic [4:0] sum, ram_din, ram_dout;
    logic [7:0] ram_addr;

    sum_table_ctrl #(.NW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .req(req), .A(A), .B(B),
        .busy(busy), .ready(ready), .ack(ack), .sum(sum), .err(err),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read, optional bit flips on the read data
    logic [4:0] mem [256];
    logic [4:0] rd_q;
    logic [4:0] corrupt;
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        rd_q <= mem[ram_addr];
        end
    end
    assign ram_dout = rd_q ^ corrupt;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] mask;
    } look_t;

    look_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    rd_cyc = 0;
    int    ack_cnt = 0;
    int    fill_idx = 0;
    bit    err_model = 1'b0;
    bit    mon_en = 1'b0;
    bit    prev_last = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors: fill writes, lookup reads, acks
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (prev_last) begin
                chk("ready_after_fill", int'(ready), 1);
                chk("busy_after_fill", int'(busy), 0);
                prev_last = 1'b0;
            end
            if (ram_cs && ram_we) begin
                chk("fill_addr", int'(ram_addr), fill_idx);
                chk("fill_din", int'(ram_din), int'(ram_addr[7:4]) + int'(ram_addr[3:0]));
                chk("fill_busy", int'(busy), 1);
                fill_idx++;
                if (fill_idx == 256) prev_last = 1'b1;
            end
            if (ram_cs && !ram_we) begin
                chk("read_when_ready", int'(ready), 1);
                if (exp_q.size() == 0) chk("read_unexpected", 1, 0);
                else chk("read_addr", int'(ram_addr), int'({exp_q[0].a, exp_q[0].b}));
                rd_cyc = cyc;
            end
            if (ack) begin
                look_t e;
                ack_cnt++;
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.mask != 5'd0) err_model = 1'b1;
                    chk("sum", int'(sum), (int'(e.a) + int'(e.b)) ^ int'(e.mask));
                    chk("err", int'(err), int'(err_model));
                    chk("latency", cyc - rd_cyc, 2);
                end
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_cs", int'(ram_cs), 0);
        chk("rst_we", int'(ram_we), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_din", int'(ram_din), 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic start_fill();
        @(posedge clk); #1;
        start = 1'b1;
        fill_idx = 0;
        err_model = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on_start", int'(busy), 1);
        chk("err_cleared_on_start", int'(err), 0);
    endtask

    task automatic lookup(input logic [3:0] a, input logic [3:0] b, input logic [4:0] mask,
                          input int hold, input bit need_ready);
        int    n;
        int    acks0;
        look_t e;
        if (need_ready) wait_ready();
        @(posedge clk); #1;
        A = a; B = b; corrupt = mask; req = 1'b1;
        e.a = a; e.b = b; e.mask = mask;
        exp_q.push_back(e);
        acks0 = ack_cnt;
        n = 0;
        while (ack_cnt == acks0 && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (ack_cnt == acks0) chk("ack_timeout", 0, 1);
        repeat (hold) @(posedge clk);
        #1;
        req = 1'b0;
        corrupt = 5'd0;
        chk("ack_count", ack_cnt - acks0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; req = 1'b0; A = '0; B = '0; corrupt = 5'd0;
        // Reset asserted mid-cycle takes effect immediately
        #3 rst = 1'b1;
        #1 check_reset_vals();
        @(posedge clk); #1 rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("idle_ready", int'(ready), 0);

        // Full fill, then directed lookups
        start_fill();
        wait_ready();
        chk("fill_count", fill_idx, 256);
        lookup(4'd3, 4'd5, 5'd0, 0, 1'b1);
        lookup(4'd15, 4'd15, 5'd0, 0, 1'b1);
        lookup(4'd0, 4'd0, 5'd0, 0, 1'b1);
        // req held high well past the ack: exactly one ack
        lookup(4'd4, 4'd7, 5'd0, 12, 1'b1);
        lookup(4'd9, 4'd6, 5'd0, 0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            lookup(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 5'd0,
                   $urandom_range(0, 3), 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // req raised during fill is served only once the table is ready
        start_fill();
        repeat (5) @(posedge clk);
        lookup(4'd2, 4'd8, 5'd0, 0, 1'b0);

        // Reset in the middle of a fill
        start_fill();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ram_cs && ram_we && ram_addr == 8'h40) && n < 400);
        chk("reached_addr_40", int'(ram_addr), 8'h40);
        #2 rst = 1'b1;
        #1 check_reset_vals();
        exp_q.delete();
        fill_idx = 0;
        err_model = 1'b0;
        prev_last = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("ready_after_reset", int'(ready), 0);

        // Refill, corrupted read sets sticky err, next start clears it
        start_fill();
        wait_ready();
        lookup(4'd3, 4'd4, 5'h04, 0, 1'b1);
        lookup(4'd1, 4'd1, 5'd0, 0, 1'b1);
        lookup(4'd12, 4'd5, 5'd0, 0, 1'b1);
        chk("err_sticky", int'(err), 1);
        start_fill();
        wait_ready();
        lookup(4'd7, 4'd8, 5'd0, 0, 1'b1);
        chk("err_final", int'(err), 0);

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
